cycle_delay_latch: RTL
======================

CYCLE_DELAY_LATCH -- requirements
Module: cycle_delay_latch

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: CK is the single clock and MR is a synchronous, active-high reset.
REQ-002 Port CK, input, 1 bit: system oscillator clock; all state changes on its rising edge.
REQ-003 Port MR, input, 1 bit: master reset, synchronous, active-high.
REQ-004 Port TERM_n, input, 1 bit: cycle-terminate from the cycle FSM; low means the current cycle ends at this edge.
REQ-005 Port CSDELAY, input, 2 bits: microcode delay field for the next cycle, with code values 0..3.
REQ-006 Port CSSHORT, input, 1 bit: microcode request for a short cycle.
REQ-007 Port CSSLOW, input, 1 bit: microcode request for a slow cycle.
REQ-008 Port STALL, input, 1 bit: freezes the delay countdown while high.
REQ-009 Port DLY0_n, output, 1 bit: delay-phase-0 pending, active-low.
REQ-010 Port DLY1_n, output, 1 bit: delay-phase-1 pending, active-low.
REQ-011 Port SHORT_n, output, 1 bit: latched short-cycle flag, active-low.
REQ-012 Port SLOW_n, output, 1 bit: latched slow-cycle flag, active-low.
REQ-013 Port TERMCNT, output, 8 bits: count of terminated cycles, used for debug and performance.

Function
REQ-014 On a rising CK with MR=0 and TERM_n=0, the block SHALL load these registers:
- CNT (2 bits) ← CSDELAY;
- SHORT_q ← CSSHORT & ~CSSLOW;
- SLOW_q ← CSSLOW.
REQ-015 When CSSHORT and CSSLOW are both 1 at a load, slow SHALL win: SHORT_q=0 and SLOW_q=1.
REQ-016 On a rising CK with MR=0, TERM_n=1, STALL=0 and CNT≠0, the block SHALL decrement CNT by 1.
REQ-017 CNT SHALL hold its value when it is 0 (no underflow or wrap) or when STALL=1.
REQ-018 TERM_n=0 SHALL take priority over STALL and decrement: the load happens even when STALL=1.
REQ-019 DLY0_n SHALL equal 0 exactly when CNT≥1, decoded directly from registered state (zero combinational input path).
REQ-020 DLY1_n SHALL equal 0 exactly when CNT≥2, decoded directly from registered state.
REQ-021 SHORT_n SHALL equal ~SHORT_q and SLOW_n SHALL equal ~SLOW_q; both hold until the next load.
REQ-022 Latency: values sampled at the TERM edge SHALL appear on the outputs in the cycle immediately after that edge (1 CK).
REQ-023 TERMCNT SHALL increment by 1 on each rising CK where TERM_n=0, and SHALL wrap from 255 to 0.
REQ-024 Back-to-back TERM_n=0 on consecutive edges SHALL reload the registers every edge; the newest CSDELAY wins.

Reset
REQ-025 MR=1 at a rising CK SHALL set CNT=0, SHORT_q=0, SLOW_q=0 and TERMCNT=0, giving output values DLY0_n=1, DLY1_n=1, SHORT_n=1, SLOW_n=1 and TERMCNT=0.
REQ-026 MR SHALL override TERM_n and STALL on the same edge.
REQ-027 A reset asserted mid-countdown SHALL abort the countdown with no residual delay.
REQ-028 All outputs SHALL be defined (no X) from the first CK edge that has MR=1.

Structure
REQ-029 The shared package cycfsm_pkg SHALL hold:
- the delay-code constants DLY_NONE=0, DLY_1=1, DLY_2=2, DLY_3=3;
- the 2-bit delay-count type, which the cycle-FSM block also uses.
REQ-030 The 2-bit saturating down-counter SHALL be the single sub-module, named dly_counter, with ports for load, load value, enable and count; all other logic stays in cycle_delay_latch.

Verification
REQ-031 Reset scenario: MR=1 for 2 CK with TERM_n=0 and CSDELAY=3 -> DLY0_n=1, DLY1_n=1, SHORT_n=1, SLOW_n=1, TERMCNT=0.
REQ-032 Countdown scenario: one TERM_n=0 pulse with CSDELAY=3, then STALL=0 -> DLY1_n,DLY0_n read 0,0 / 0,0 / 1,0 / 1,1 over the 4 following cycles, then hold at 1,1.
REQ-033 Stall scenario: CSDELAY=2 loaded, then STALL=1 for 3 CK -> DLY1_n=0 and DLY0_n=0 are held for 3 extra cycles; then the countdown resumes (CNT 2→1→0).
REQ-034 Priority scenario: CSSHORT=1 and CSSLOW=1 at TERM -> SHORT_n=1 and SLOW_n=0; a following TERM with only CSSHORT=1 -> SHORT_n=0 and SLOW_n=1.
REQ-035 Wrap scenario: 256 consecutive TERM_n=0 edges from reset -> TERMCNT counts 1..255, then reads 0, and a reload occurs on every edge.
REQ-036 Mid-reset scenario: CSDELAY=3 loaded, then MR=1 at the next edge alongside TERM_n=0 with CSDELAY=2 -> CNT=0, DLY0_n=1, TERMCNT=0.

Source files
------------

// File: rtl/cycfsm_pkg.sv
// rtl/cycfsm_pkg.sv - shared delay-code constants and delay-count type for the cycle FSM blocks
package cycfsm_pkg;

    // 2-bit delay count, shared with the cycle-FSM block
    typedef logic [1:0] dly_cnt_t;

    // Microcode delay-field codes
    localparam dly_cnt_t DLY_NONE = 2'd0;
    localparam dly_cnt_t DLY_1    = 2'd1;
    localparam dly_cnt_t DLY_2    = 2'd2;
    localparam dly_cnt_t DLY_3    = 2'd3;

endpackage

// File: rtl/dly_counter.sv
// rtl/dly_counter.sv - 2-bit loadable saturating down-counter
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset, clears count
//   load       - load load_value (wins over enable)
//   load_value - value to load
//   enable     - decrement by one when count is non-zero
//   count      - current count
module dly_counter
    import cycfsm_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  dly_cnt_t load_value,
    input  logic     enable,
    output dly_cnt_t count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= DLY_NONE;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != DLY_NONE)) begin
            // Saturate at zero: no wrap to 3
            count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/cycle_delay_latch.sv
// rtl/cycle_delay_latch.sv - latches microcode delay/short/slow fields at cycle end and counts terminated cycles
//
// Ports:
//   CK      - clock, all state changes on rising edge
//   MR      - synchronous active-high master reset
//   TERM_n  - low: current cycle ends at this edge, load the fields
//   CSDELAY - delay code for the next cycle (0..3)
//   CSSHORT - short-cycle request
//   CSSLOW  - slow-cycle request (wins over short)
//   STALL   - freezes the delay countdown while high
//   DLY0_n  - low while delay count >= 1
//   DLY1_n  - low while delay count >= 2
//   SHORT_n - latched short flag, active-low
//   SLOW_n  - latched slow flag, active-low
//   TERMCNT - wrapping count of terminated cycles
module cycle_delay_latch
    import cycfsm_pkg::*;
(
    input  logic       CK,
    input  logic       MR,
    input  logic       TERM_n,
    input  logic [1:0] CSDELAY,
    input  logic       CSSHORT,
    input  logic       CSSLOW,
    input  logic       STALL,
    output logic       DLY0_n,
    output logic       DLY1_n,
    output logic       SHORT_n,
    output logic       SLOW_n,
    output logic [7:0] TERMCNT
);

    dly_cnt_t   cnt;
    logic       short_q;
    logic       slow_q;
    logic [7:0] term_count;

    dly_counter u_dly_counter (
        .clk        (CK),
        .rst        (MR),
        .load       (~TERM_n),
        .load_value (CSDELAY),
        .enable     (~STALL),
        .count      (cnt)
    );

    always_ff @(posedge CK) begin
        if (MR) begin
            short_q    <= 1'b0;
            slow_q     <= 1'b0;
            term_count <= 8'd0;
        end else if (!TERM_n) begin
            // Slow overrides short when both are requested
            short_q    <= CSSHORT & ~CSSLOW;
            slow_q     <= CSSLOW;
            term_count <= term_count + 8'd1;
        end
    end

    // Outputs decode registered state only
    assign DLY0_n  = ~(cnt != DLY_NONE);
    assign DLY1_n  = ~(cnt >= DLY_2);
    assign SHORT_n = ~short_q;
    assign SLOW_n  = ~slow_q;
    assign TERMCNT = term_count;

endmodule
